ps2_keycode_rx: RTL and testbench
=================================

Name: ps2_keycode_rx

Overview:
PS/2 keyboard receiver feeding the keyboard movement-control stage. It synchronises and filters the raw PS/2 clock and data lines and deframes 11-bit device-to-host frames. Each valid byte is shifted into a 16-bit keycode history ({previous byte, latest byte}), so a break sequence appears as 16'hF0xx. It also emits a one-cycle valid strobe and an error strobe for rejected frames.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised ps2_clk samples required before the filtered clock changes level
TIMEOUT_CYCLES, 65000, clk cycles allowed between filtered falling edges inside a frame before the frame is aborted (1 ms at 65 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from pin, asynchronous
ps2_data  input  1  raw PS/2 data from pin, asynchronous
keycode  output  16  [15:8] previous accepted byte, [7:0] latest accepted byte
keycode_valid  output  1  one-cycle pulse when keycode has just been updated
frame_err  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (asynchronous, active-low): keycode=16'h0000, keycode_valid=0, frame_err=0, FSM=IDLE, shift register, bit counter and timeout counter cleared, filtered clock=1. Reset asserted mid-frame discards the partial frame.
- Input conditioning: 2-FF synchroniser on each line. The filtered clock takes the synchronised level only after FILTER_LEN consecutive equal samples. A falling edge (fe) is a 1-cycle pulse when the filtered clock goes 1->0. Data is sampled from synchronised ps2_data in the fe cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe, if data=0 (start bit) go to DATA with bit counter=0. If data=1, stay in IDLE with no error pulse.
  - DATA: on each fe, shift data in LSB first and increment the counter. After the 8th bit, go to PARITY.
  - PARITY: on fe, store the bit and go to STOP.
  - STOP: on fe, go to IDLE. If stop=1 and parity is accepted, the frame is good; otherwise frame_err pulses.
- Good frame: in the cycle after the stop-bit fe, keycode <= {keycode[7:0], byte} and keycode_valid=1 for exactly one cycle. On any error, keycode is unchanged.
- Parity is odd over 8 data bits plus the parity bit.
- Latency: keycode_valid asserts no later than 2+FILTER_LEN+2 clk cycles after the raw ps2_clk falling edge of the stop bit.
- Timeout: in DATA/PARITY/STOP, a counter counts cycles since the last fe. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, frame_err pulses once, and keycode is unchanged. The counter saturates and is cleared on each fe and in IDLE. Its width is $clog2(TIMEOUT_CYCLES+1).
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no fe.
- keycode_valid and frame_err are never high in the same cycle.
- No back-pressure: the consumer samples keycode whenever it likes. keycode holds its value between valid pulses.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a parity mismatch rejects the frame (frame_err pulse, no keycode update).
- Undefined: the parity bit is sampled and ignored. Only a bad stop bit or a timeout produces frame_err.

Decomposition:
- Package ps2_pkg:
  - state enum type ps2_state_t (IDLE, DATA, PARITY, STOP)
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_DATA_BITS=8
- Sub-module ps2_line_sync: synchroniser, FILTER_LEN glitch filter and falling-edge detect. Outputs data_s and fe.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles, then release -> keycode=16'h0000, keycode_valid=0, frame_err=0.
- Send frame 0x1D (parity 1, stop 1) at 12.5 kHz -> exactly one keycode_valid pulse, keycode=16'h001D.
- Send 0x23, then 0xF0, then 0x23 -> after each byte keycode=16'h1D23, then 16'h23F0, then 16'hF023, with exactly three valid pulses.
- Send 0x1C with wrong parity bit 1 -> with PS2_PARITY_CHECK_EN: frame_err pulse, keycode unchanged; without it: keycode_valid pulse, keycode[7:0]=8'h1C.
- Send start plus 4 data bits, then stall ps2_clk high for TIMEOUT_CYCLES+10 -> single frame_err pulse, FSM in IDLE; a following full 0x1B frame -> keycode[7:0]=8'h1B.
- Inject 3-cycle low glitches on ps2_clk during a 0x1D frame (FILTER_LEN=8), and in a separate run assert rst_n low mid-frame -> the glitched frame is still received as 0x1D; the reset run gives keycode=16'h0000, and the next clean frame is received normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0]  PS2_BREAK     = 8'hF0;
  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam int unsigned PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Keycode output bundle: the receiver drives it, the movement-control stage samples it.
interface ps2_keycode_rx_if;

  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;

  modport master (output keycode, output keycode_valid, output frame_err);
  modport slave  (input  keycode, input  keycode_valid, input  frame_err);

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers on the PS/2 lines, a FILTER_LEN-sample glitch filter on the clock
// and a one-cycle falling-edge strobe of the filtered clock.
module ps2_line_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fe
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fe_q, fe_d;
  logic          clk_s;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = fe_q;

  // cnt_q counts consecutive samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fe_d   = 1'b0;
    if (clk_s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = clk_s;
        fe_d   = ~clk_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fe_q        <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fe_q        <= fe_d;
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host deframer building a 16-bit {previous, latest} keycode history.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keycode_rx_if.master  key_bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic          data_s, fe;
  ps2_state_t    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   key_q, key_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          parity_ok;

  ps2_line_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fe       (fe)
  );

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (state_q == PARITY && fe) begin
      parity_q <= data_s;
    end
  end

  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q == IDLE || fe) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (fe && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fe) begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fe) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          state_d = IDLE;
          if (data_s && parity_ok) begin
            key_d   = {key_q[7:0], shift_q};
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; a real edge in the same cycle takes precedence.
    if (state_q != IDLE && !fe && tmo_q == TMO_MAX) begin
      state_d = IDLE;
      key_d   = key_q;
      valid_d = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign key_bus.keycode       = key_q;
  assign key_bus.keycode_valid = valid_q;
  assign key_bus.frame_err     = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx with an event-queue model of accepted/rejected frames.
module tb_ps2_keycode_rx;
  import ps2_pkg::*;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 200;
  localparam int          H    = 20;  // half period of the PS/2 clock in clk cycles

  logic clk = 1'b0;
  logic rst_n;
  logic ps2_clk;
  logic ps2_data;

  ps2_keycode_rx_if key_bus ();

  ps2_keycode_rx #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_bus  (key_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] key;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] model_key = 16'h0000;
  logic [15:0] cur_exp   = 16'h0000;
  int          tests     = 0;
  int          fails     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame: start 0, data LSB first, odd parity (optionally inverted), stop 1.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip);
    logic par;
    par = ~(^b) ^ flip;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic expect_good(input logic [7:0] b);
    ev_t e;
    model_key = {model_key[7:0], b};
    e.is_err  = 1'b0;
    e.key     = model_key;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    ev_t e;
    e.is_err = 1'b1;
    e.key    = model_key;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = frame[i];
      if (glitch && (i == 3 || i == 7)) begin
        wait_cyc(6);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(H - 9);
      end else begin
        wait_cyc(H);
      end
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(H);
  endtask

  task automatic wait_drain(input string name, input int max);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_key(input string name, input logic [15:0] exp);
    @(negedge clk);
    chk(name, key_bus.keycode, exp);
  endtask

  // Every cycle: events must match the model queue in order, keycode must hold otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_keycode", key_bus.keycode, 0);
      chk("rst_valid", key_bus.keycode_valid, 0);
      chk("rst_err", key_bus.frame_err, 0);
    end else begin
      if (key_bus.keycode_valid && key_bus.frame_err) begin
        chk("valid_and_err", 1, 0);
      end
      if (key_bus.keycode_valid || key_bus.frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {key_bus.keycode_valid, key_bus.frame_err}, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_is_err", key_bus.frame_err, e.is_err);
          chk("event_keycode", key_bus.keycode, e.key);
          cur_exp = e.key;
        end
      end else begin
        chk("keycode_hold", key_bus.keycode, cur_exp);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(2);
    chk_key("reset_keycode", 16'h0000);

    expect_good(8'h1D);
    send_bits(mk_frame(8'h1D, 1'b0), 11, 1'b0);
    wait_drain("1D", 4);
    chk_key("key_001D", 16'h001D);

    expect_good(8'h23);
    send_bits(mk_frame(8'h23, 1'b0), 11, 1'b0);
    wait_drain("23", 4);
    chk_key("key_1D23", 16'h1D23);

    expect_good(PS2_BREAK);
    send_bits(mk_frame(PS2_BREAK, 1'b0), 11, 1'b0);
    wait_drain("F0", 4);
    chk_key("key_23F0", 16'h23F0);

    expect_good(8'h23);
    send_bits(mk_frame(8'h23, 1'b0), 11, 1'b0);
    wait_drain("23b", 4);
    chk_key("key_F023", 16'hF023);

`ifdef PS2_PARITY_CHECK_EN
    expect_err();
    send_bits(mk_frame(8'h1C, 1'b1), 11, 1'b0);
    wait_drain("1C_badpar", 4);
    chk_key("key_badpar_kept", 16'hF023);
`else
    expect_good(8'h1C);
    send_bits(mk_frame(8'h1C, 1'b1), 11, 1'b0);
    wait_drain("1C_badpar", 4);
    chk_key("key_badpar_taken", 16'h231C);
`endif

    expect_good(PS2_EXT);
    send_bits(mk_frame(PS2_EXT, 1'b0), 11, 1'b0);
    wait_drain("E0", 4);
`ifdef PS2_PARITY_CHECK_EN
    chk_key("key_23E0", 16'h23E0);
`else
    chk_key("key_1CE0", 16'h1CE0);
`endif

    // Bad stop bit.
    expect_err();
    send_bits({1'b0, mk_frame(8'h44, 1'b0) & 11'h3FF} , 11, 1'b0);
    wait_drain("badstop", 4);
    chk_key("key_badstop_kept", model_key);

    // Start plus four data bits, then the clock stalls high.
    expect_err();
    send_bits(mk_frame(8'h1B, 1'b0), 5, 1'b0);
    wait_cyc(TMO + 10);
    wait_drain("timeout", 40);

    expect_good(8'h1B);
    send_bits(mk_frame(8'h1B, 1'b0), 11, 1'b0);
    wait_drain("1B", 4);
    chk_key("key_E01B", 16'hE01B);

    expect_good(8'h1D);
    send_bits(mk_frame(8'h1D, 1'b0), 11, 1'b1);
    wait_drain("1D_glitch", 4);
    chk_key("key_1B1D", 16'h1B1D);

    // Reset in the middle of a frame throws the partial frame away.
    send_bits(mk_frame(8'h55, 1'b0), 4, 1'b0);
    rst_n     = 1'b0;
    model_key = 16'h0000;
    cur_exp   = 16'h0000;
    exp_q.delete();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(2);
    chk_key("key_after_rst", 16'h0000);

    expect_good(8'h1D);
    send_bits(mk_frame(8'h1D, 1'b0), 11, 1'b0);
    wait_drain("1D_post_rst", 4);
    chk_key("key_post_rst", 16'h001D);

    wait_cyc(TMO + 20);
    chk("idle_no_events", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
